// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: definitions shared by the NEC IR transmit and receive blocks.
//   - nec_state_e : 3-bit frame sequencer state encoding
//   - NEC_*_DUR   : default NEC timing in clocks at 50 MHz
//   - NEC_FRAME_BITS, byte field positions of the 32-bit code word
//   - nec_tx_word : builds the on-air word from the host code word
package ir_nec_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StLeadMark  = 3'd1,
    StLeadSpace = 3'd2,
    StBitMark   = 3'd3,
    StBitSpace  = 3'd4,
    StStopMark  = 3'd5,
    StGap       = 3'd6
  } nec_state_e;

  localparam int unsigned NEC_LEAD_MARK_DUR  = 450000;
  localparam int unsigned NEC_LEAD_SPACE_DUR = 225000;
  localparam int unsigned NEC_BIT_MARK_DUR   = 28000;
  localparam int unsigned NEC_ZERO_SPACE_DUR = 28000;
  localparam int unsigned NEC_ONE_SPACE_DUR  = 84500;
  localparam int unsigned NEC_GAP_DUR        = 2000000;
  localparam int unsigned NEC_CARRIER_HALF   = 658;

  // Duration counter width; the 40 ms gap is the longest interval.
  localparam int unsigned NEC_CNT_W = 22;

  localparam int unsigned NEC_FRAME_BITS = 32;

  localparam int unsigned NEC_ADDR_LSB = 0;
  localparam int unsigned NEC_EXT_LSB  = 8;
  localparam int unsigned NEC_CMD_LSB  = 16;
  localparam int unsigned NEC_INV_LSB  = 24;

  // With auto_inv set, the top byte is regenerated as the inverted command.
  function automatic logic [31:0] nec_tx_word(input logic [31:0] data, input logic auto_inv);
    logic [31:0] w;
    w                    = '0;
    w[NEC_ADDR_LSB +: 8] = data[NEC_ADDR_LSB +: 8];
    w[NEC_EXT_LSB +: 8]  = data[NEC_EXT_LSB +: 8];
    w[NEC_CMD_LSB +: 8]  = data[NEC_CMD_LSB +: 8];
    w[NEC_INV_LSB +: 8]  = auto_inv ? ~data[NEC_CMD_LSB +: 8] : data[NEC_INV_LSB +: 8];
    return w;
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: IR carrier square wave, gated by an enable.
//   iCLK      in  system clock
//   iRST_n    in  asynchronous active-low reset
//   iEN       in  carrier enable (high during marks)
//   oCARRIER  out carrier, 1 for the first CARRIER_HALF clocks after iEN rises,
//                 then toggling every CARRIER_HALF clocks; 0 while iEN is low
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int unsigned CARRIER_HALF = NEC_CARRIER_HALF
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic iEN,
  output logic oCARRIER
);

  localparam int unsigned CntW = $clog2(CARRIER_HALF + 1);

  logic [CntW-1:0] cnt_q;
  logic            phase_q;

  // While disabled the counter is parked with phase 1 so every mark starts high.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (!iEN) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == CntW'(CARRIER_HALF - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign oCARRIER = iEN & phase_q;

endmodule

// File: rtl/ir_nec_transmit.sv
// ir_nec_transmit: NEC-format infrared frame transmitter.
// Sends leader, 32 data bits LSB first, stop mark and a minimum gap.
//   iCLK    in  system clock (50 MHz)
//   iRST_n  in  asynchronous active-low reset
//   iSEND   in  start request, sampled only while oBUSY=0
//   iDATA   in  32-bit code word {~cmd, cmd, addr/ext, addr}
//   oBUSY   out frame in progress, leader through end of gap
//   oDONE   out one-cycle pulse on the last gap clock
//   oIRDA   out baseband level, 0 during marks
//   oIRLED  out LED drive, 1 = LED on
// Build option: IR_NEC_TX_CARRIER_EN defined -> oIRLED is the mark gated with a
// 38 kHz carrier from ir_carrier_gen; undefined -> oIRLED = ~oIRDA.
module ir_nec_transmit
  import ir_nec_pkg::*;
#(
  parameter int unsigned LEAD_MARK_DUR  = NEC_LEAD_MARK_DUR,
  parameter int unsigned LEAD_SPACE_DUR = NEC_LEAD_SPACE_DUR,
  parameter int unsigned BIT_MARK_DUR   = NEC_BIT_MARK_DUR,
  parameter int unsigned ZERO_SPACE_DUR = NEC_ZERO_SPACE_DUR,
  parameter int unsigned ONE_SPACE_DUR  = NEC_ONE_SPACE_DUR,
  parameter int unsigned GAP_DUR        = NEC_GAP_DUR,
  parameter int unsigned CARRIER_HALF   = NEC_CARRIER_HALF,
  parameter bit          AUTO_INV       = 1'b1
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSEND,
  input  logic [31:0] iDATA,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oIRDA,
  output logic        oIRLED
);

  localparam int unsigned CntW = NEC_CNT_W;
  localparam int unsigned BitW = $clog2(NEC_FRAME_BITS);

  nec_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] dur_last;
  logic [BitW-1:0] bitcnt_q, bitcnt_d;
  logic [31:0]     shreg_q, shreg_d;
  logic            pend_q, pend_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            irda_q, irda_d;
  logic            last;

  // Terminal count of the current timed state.
  always_comb begin
    dur_last = '0;
    case (state_q)
      StLeadMark:            dur_last = CntW'(LEAD_MARK_DUR - 1);
      StLeadSpace:           dur_last = CntW'(LEAD_SPACE_DUR - 1);
      StBitMark, StStopMark: dur_last = CntW'(BIT_MARK_DUR - 1);
      StBitSpace:            dur_last = shreg_q[0] ? CntW'(ONE_SPACE_DUR - 1)
                                                   : CntW'(ZERO_SPACE_DUR - 1);
      StGap:                 dur_last = CntW'(GAP_DUR - 1);
      default:               dur_last = '0;
    endcase
  end

  assign last = (cnt_q == dur_last);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    pend_d   = pend_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // The word is latched one edge before the leader starts; a request
        // seen while that load is pending is ignored.
        if (pend_q) begin
          pend_d   = 1'b0;
          bitcnt_d = '0;
          state_d  = StLeadMark;
        end else if (iSEND) begin
          pend_d  = 1'b1;
          shreg_d = nec_tx_word(iDATA, AUTO_INV);
        end
      end
      StLeadMark:  if (last) state_d = StLeadSpace;
      StLeadSpace: if (last) state_d = StBitMark;
      StBitMark:   if (last) state_d = StBitSpace;
      StBitSpace: begin
        if (last) begin
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + 1'b1;
          state_d  = (bitcnt_q == BitW'(NEC_FRAME_BITS - 1)) ? StStopMark : StBitMark;
        end
      end
      StStopMark:  if (last) state_d = StGap;
      StGap:       if (last) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are registered from next state so they change cleanly on the edge.
  always_comb begin
    irda_d = !(state_d inside {StLeadMark, StBitMark, StStopMark});
    busy_d = (state_d != StIdle);
    done_d = (state_d == StGap) && (cnt_d == CntW'(GAP_DUR - 1));
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      irda_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      irda_q   <= irda_d;
    end
  end

  assign oBUSY = busy_q;
  assign oDONE = done_q;
  assign oIRDA = irda_q;

`ifdef IR_NEC_TX_CARRIER_EN
  logic mark;
  logic carrier;

  assign mark = ~irda_q;

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iEN     (mark),
    .oCARRIER(carrier)
  );

  assign oIRLED = mark & carrier;
`else
  // Baseband drive for an external modulator; the carrier period is not needed.
  logic unused_carrier_half;
  assign unused_carrier_half = ^CARRIER_HALF;

  assign oIRLED = ~irda_q;
`endif

endmodule
